key_debounce: RTL and testbench
===============================

# key_debounce

Multi-key debouncer that consumes the slow sampling clock from the sample-time stage and turns raw, bouncing push-button inputs into clean levels and single-cycle event pulses in the Clk_50MHz domain. It sits between the board buttons and the clock-setting control logic. sample_clk is used only as a data input, never as a clock. Each rising edge of sample_clk advances every key's debounce history by one sample.

## Interface

Parameters:
- N_KEYS, 4, number of independent keys.
- STABLE_N, 4, consecutive agreeing samples (tick-rate) needed to change a debounced level; range 2..8.
- REPEAT_DLY, 20, ticks a key must be held before the first auto-repeat pulse; range 1..255 (used only with KEY_REPEAT_EN).
- REPEAT_PER, 5, ticks between subsequent auto-repeat pulses; range 1..255 (used only with KEY_REPEAT_EN).

Ports:
- Clk_50MHz, input, 1, system clock; the only clock.
- Reset_N, input, 1, asynchronous active-low reset.
- sample_clk, input, 1, sampling square wave from the sample-time stage; asynchronous to this block's logic view.
- key_in, input, N_KEYS, raw buttons, active-low (0 = pressed).
- key_state, output, N_KEYS, debounced level, active-high (1 = pressed).
- key_press, output, N_KEYS, one-cycle pulse per press event (and per repeat when enabled).
- key_release, output, N_KEYS, one-cycle pulse per release event.

## Operation

Synchronizing and tick generation:
- key_in and sample_clk each pass through a 2-FF synchronizer. Synchronizer reset value is 1 for key_in and 0 for sample_clk.
- A third register on synchronized sample_clk feeds a rising-edge detector. tick is high for exactly one Clk_50MHz cycle per sample_clk rising edge. Falling edges are ignored.

Per key (independent; all keys share tick):
- hist is a STABLE_N-1 bit history of the inverted, synchronized key. On a tick cycle, s = current inverted sync sample, and hist shifts in s at that edge.
- On the same edge, key_state changes only if s and all STABLE_N-1 hist bits equal each other and differ from key_state. key_state then takes s.
- key_press is asserted for one cycle on the edge where key_state goes 0->1.
- key_release is asserted for one cycle on the edge where key_state goes 1->0.
- Outside tick cycles, hist, key_state, and the repeat counter hold. Pulses are 0 outside tick cycles.
- Two-state FSM per key, IDLE (key_state=0) and HELD (key_state=1). The transitions are exactly the level changes defined above.

Reset:
- Asynchronous. All outputs go to 0, hist is cleared to all-0 (released), and repeat counters are cleared.
- Reset asserted mid-press discards the history. After release of Reset_N, a held key needs STABLE_N fresh ticks before key_state reasserts, and then produces a new key_press.

## Timing

- Latency from a clean key_in edge to key_state/key_press is 2 synchronizer cycles, plus waiting for tick, plus STABLE_N ticks total of agreeing samples. With the default STABLE_N, the level changes on the 4th tick after the input settles.
- Any disagreeing sample within the window restarts the count. A bounce shorter than one tick period may be missed entirely; this is acceptable.
- key_press and key_state rise on the same clock edge. key_release and key_state fall on the same clock edge.
- Different keys may pulse on the same cycle.
- Outputs are registered, with no combinational path from inputs.

## Configuration

- KEY_REPEAT_EN defined:
  - Each key has an 8-bit tick counter, cleared on entry to HELD.
  - While HELD, the counter increments on each tick.
  - When it reaches REPEAT_DLY, key_press pulses on that tick and the counter reloads to REPEAT_DLY-REPEAT_PER.
  - This produces further pulses every REPEAT_PER ticks.
  - Release (HELD->IDLE) clears the counter; any repeat is cancelled on the same edge that asserts key_release.
- KEY_REPEAT_EN undefined:
  - No counters are synthesized, and REPEAT_DLY/REPEAT_PER are unused.
  - key_press fires exactly once per press.

## Test plan

- Reset: hold Reset_N=0 with key_in=4'b0000 and sample_clk toggling -> key_state=0, key_press=0, key_release=0. Release reset -> key_state[3:0]=4'b1111 after exactly 4 ticks, with a 4'b1111 key_press pulse on that cycle.
- Bounce rejection: key_in[0] pattern 0,1,0,0,1,0,0,0,0 sampled once per tick -> a single key_press[0] pulse, coincident with the 4th consecutive 0. No key_release[0].
- Clean press/release: key_in[2] low for 10 ticks, then high -> key_state[2] is high from tick 4 to tick 13, with exactly one key_press[2] and one key_release[2], each 1 cycle wide.
- Tick qualification: sample_clk held constant for 1000 cycles while key_in changes -> no output change. The first rising edge then counts as one sample only.
- Repeat (KEY_REPEAT_EN): key_in[1] held 40 ticks -> key_press[1] at press, then at hold ticks 20, 25, 30, 35, 40 (6 pulses total). Releasing at tick 22 instead gives exactly 2 pulses.
- Mid-operation reset: assert Reset_N for 3 cycles while key_state[3]=1 -> immediate zero outputs. After release, key_state[3] reasserts after 4 ticks with a new key_press[3].

Source files
------------

// File: rtl/key_debounce.sv
// Multi-key debouncer: synced raw keys are sampled on each sample_clk rising edge; a level flips after STABLE_N agreeing samples.
// Outputs are registered, with press/release pulses one clock wide. Define KEY_REPEAT_EN to add per-key auto-repeat on key_press.
module key_debounce #(
  parameter int N_KEYS     = 4,
  parameter int STABLE_N   = 4,
  parameter int REPEAT_DLY = 20,
  parameter int REPEAT_PER = 5
) (
  input  logic              Clk_50MHz,
  input  logic              Reset_N,
  input  logic              sample_clk,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int HW = STABLE_N - 1;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} key_st_e;

  logic [N_KEYS-1:0] ksync1_q, ksync2_q;
  logic              smp1_q, smp2_q, smp3_q;
  logic              tick;

  logic [HW-1:0]     hist_q [N_KEYS];
  logic [HW-1:0]     hist_d [N_KEYS];
  key_st_e           st_q   [N_KEYS];
  key_st_e           st_d   [N_KEYS];
  logic [N_KEYS-1:0] press_q, press_d, rel_q, rel_d;
  logic [N_KEYS-1:0] smp_s, all_on, all_off;

`ifdef KEY_REPEAT_EN
  logic [7:0]        rpt_q [N_KEYS];
  logic [7:0]        rpt_d [N_KEYS];
`else
  logic [15:0]       rpt_cfg_unused;
  assign rpt_cfg_unused = {8'(REPEAT_DLY), 8'(REPEAT_PER)};
`endif

  // Only the sample_clk rising edge advances the debounce state.
  assign tick = smp2_q & ~smp3_q;

  always_comb begin
    smp_s   = '0;
    all_on  = '0;
    all_off = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      smp_s[k]   = ~ksync2_q[k];
      all_on[k]  = smp_s[k] & (&hist_q[k]);
      all_off[k] = ~smp_s[k] & ~(|hist_q[k]);
    end
  end

  always_comb begin
    press_d = '0;
    rel_d   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      hist_d[k] = hist_q[k];
      st_d[k]   = st_q[k];
`ifdef KEY_REPEAT_EN
      rpt_d[k]  = rpt_q[k];
`endif
      if (tick) begin
        hist_d[k] = HW'({hist_q[k], smp_s[k]});
        case (st_q[k])
          IDLE: begin
            if (all_on[k]) begin
              st_d[k]    = HELD;
              press_d[k] = 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_d[k]   = 8'd0;
`endif
            end
          end
          HELD: begin
            if (all_off[k]) begin
              st_d[k]  = IDLE;
              rel_d[k] = 1'b1;
`ifdef KEY_REPEAT_EN
              rpt_d[k] = 8'd0;
`endif
            end else begin
`ifdef KEY_REPEAT_EN
              // Reload keeps the spacing after the first repeat at REPEAT_PER ticks.
              if (rpt_q[k] + 8'd1 == 8'(REPEAT_DLY)) begin
                press_d[k] = 1'b1;
                rpt_d[k]   = 8'(REPEAT_DLY - REPEAT_PER);
              end else begin
                rpt_d[k]   = rpt_q[k] + 8'd1;
              end
`endif
            end
          end
          default: st_d[k] = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      ksync1_q <= '1;
      ksync2_q <= '1;
      smp1_q   <= 1'b0;
      smp2_q   <= 1'b0;
      smp3_q   <= 1'b0;
      press_q  <= '0;
      rel_q    <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        hist_q[k] <= '0;
        st_q[k]   <= IDLE;
`ifdef KEY_REPEAT_EN
        rpt_q[k]  <= 8'd0;
`endif
      end
    end else begin
      ksync1_q <= key_in;
      ksync2_q <= ksync1_q;
      smp1_q   <= sample_clk;
      smp2_q   <= smp1_q;
      smp3_q   <= smp2_q;
      press_q  <= press_d;
      rel_q    <= rel_d;
      for (int k = 0; k < N_KEYS; k++) begin
        hist_q[k] <= hist_d[k];
        st_q[k]   <= st_d[k];
`ifdef KEY_REPEAT_EN
        rpt_q[k]  <= rpt_d[k];
`endif
      end
    end
  end

  always_comb begin
    key_state = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      key_state[k] = (st_q[k] == HELD);
    end
  end

  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: per-tick vector table plus hand sequences for tick gating, auto-repeat and mid-press reset.
module tb_key_debounce;

  logic       Clk_50MHz = 1'b0;
  logic       Reset_N;
  logic       sample_clk;
  logic [3:0] key_in;
  logic [3:0] key_state, key_press, key_release;

  key_debounce dut (
    .Clk_50MHz  (Clk_50MHz),
    .Reset_N    (Reset_N),
    .sample_clk (sample_clk),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #10 Clk_50MHz = ~Clk_50MHz;

  int total = 0;
  int bad   = 0;

  int press_tot [4] = '{default: 0};
  int rel_tot   [4] = '{default: 0};
  int wide_cnt      = 0;
  logic [3:0] prev_press = '0;
  logic [3:0] prev_rel   = '0;

  always @(negedge Clk_50MHz) begin
    for (int k = 0; k < 4; k++) begin
      press_tot[k] += int'(key_press[k]);
      rel_tot[k]   += int'(key_release[k]);
    end
    if (((key_press & prev_press) != 4'b0) || ((key_release & prev_rel) != 4'b0))
      wide_cnt++;
    prev_press = key_press;
    prev_rel   = key_release;
  end

  typedef struct {
    logic [3:0] kin;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] kin, st, pr, rl);
    vec_t v;
    v.kin = kin; v.st = st; v.pr = pr; v.rl = rl;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic do_tick(input logic [3:0] kin);
    @(negedge Clk_50MHz);
    key_in = kin;
    repeat (4) @(negedge Clk_50MHz);
    sample_clk = 1'b1;
    repeat (5) @(negedge Clk_50MHz);
    sample_clk = 1'b0;
    repeat (5) @(negedge Clk_50MHz);
  endtask

  // One tick, then compare level and which keys pulsed during it.
  task automatic tick_chk(input string tag, input logic [3:0] kin, st, pr, rl);
    int p0 [4];
    int r0 [4];
    logic [3:0] pm, rm;
    p0 = press_tot;
    r0 = rel_tot;
    do_tick(kin);
    for (int k = 0; k < 4; k++) begin
      pm[k] = (press_tot[k] != p0[k]);
      rm[k] = (rel_tot[k] != r0[k]);
    end
    check({tag, "_state"}, 32'(key_state), 32'(st));
    check({tag, "_press"}, 32'(pm), 32'(pr));
    check({tag, "_rel"}, 32'(rm), 32'(rl));
  endtask

  initial begin
    int quiet;
    int p1, r1, exp_rep;
    logic [3:0] bnc [9];

    Reset_N    = 1'b0;
    sample_clk = 1'b0;
    key_in     = 4'b0000;

    // Table: all pressed out of reset, release all, bounce on key0, clean press on key2.
    for (int i = 0; i < 3; i++) add(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 4'b1111, 4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) add(4'b1111, 4'b1111, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0000, 4'b1111);
    bnc = '{4'b1110, 4'b1111, 4'b1110, 4'b1110, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1110};
    for (int i = 0; i < 8; i++) add(bnc[i], 4'b0000, 4'b0000, 4'b0000);
    add(bnc[8], 4'b0001, 4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) add(4'b1111, 4'b0001, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0000, 4'b0001);
    for (int i = 0; i < 3; i++) add(4'b1011, 4'b0000, 4'b0000, 4'b0000);
    add(4'b1011, 4'b0100, 4'b0100, 4'b0000);
    for (int i = 0; i < 6; i++) add(4'b1011, 4'b0100, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) add(4'b1111, 4'b0100, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0000, 4'b0100);

    // Reset held with keys pressed and sample_clk toggling.
    for (int i = 0; i < 5; i++) do_tick(4'b0000);
    check("rst_state", 32'(key_state), 32'h0);
    check("rst_press", 32'(key_press), 32'h0);
    check("rst_rel", 32'(key_release), 32'h0);
    check("rst_press_cnt", 32'(press_tot[0] + press_tot[1] + press_tot[2] + press_tot[3]), 32'h0);
    @(negedge Clk_50MHz);
    Reset_N = 1'b1;

    foreach (vecs[i])
      tick_chk($sformatf("vec%0d", i), vecs[i].kin, vecs[i].st, vecs[i].pr, vecs[i].rl);

    // sample_clk frozen: key_in noise must not move anything.
    quiet = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk_50MHz);
      key_in = 4'($urandom);
      if ((key_state | key_press | key_release) != 4'b0) quiet++;
    end
    check("qual_quiet", 32'(quiet), 32'h0);
    tick_chk("qual_t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("qual_t2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("qual_t3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("qual_t4", 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    for (int i = 0; i < 3; i++) do_tick(4'b1111);
    tick_chk("qual_rel", 4'b1111, 4'b0000, 4'b0000, 4'b1111);

    // Long hold on key1 (44 ticks low = press plus 40 held ticks).
`ifdef KEY_REPEAT_EN
    exp_rep = 6;
`else
    exp_rep = 1;
`endif
    p1 = press_tot[1]; r1 = rel_tot[1];
    for (int i = 0; i < 44; i++) do_tick(4'b1101);
    check("rep_long_state", 32'(key_state), 32'h2);
    for (int i = 0; i < 4; i++) do_tick(4'b1111);
    check("rep_long_press", 32'(press_tot[1] - p1), 32'(exp_rep));
    check("rep_long_rel", 32'(rel_tot[1] - r1), 32'h1);
`ifdef KEY_REPEAT_EN
    exp_rep = 2;
`else
    exp_rep = 1;
`endif
    p1 = press_tot[1]; r1 = rel_tot[1];
    for (int i = 0; i < 22; i++) do_tick(4'b1101);
    for (int i = 0; i < 4; i++) do_tick(4'b1111);
    check("rep_short_press", 32'(press_tot[1] - p1), 32'(exp_rep));
    check("rep_short_rel", 32'(rel_tot[1] - r1), 32'h1);
    check("rep_short_state", 32'(key_state), 32'h0);

    // Reset in the middle of a held key3.
    for (int i = 0; i < 3; i++) do_tick(4'b0111);
    tick_chk("mid_press", 4'b0111, 4'b1000, 4'b1000, 4'b0000);
    @(negedge Clk_50MHz);
    Reset_N = 1'b0;
    #1;
    check("mid_rst_state", 32'(key_state), 32'h0);
    check("mid_rst_press", 32'(key_press), 32'h0);
    check("mid_rst_rel", 32'(key_release), 32'h0);
    repeat (3) @(negedge Clk_50MHz);
    Reset_N = 1'b1;
    tick_chk("mid_t1", 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("mid_t2", 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("mid_t3", 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    tick_chk("mid_t4", 4'b0111, 4'b1000, 4'b1000, 4'b0000);

    check("pulse_width", 32'(wide_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
